// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module : multicycle_ctrl_pkg
// Brief  : Shared opcodes, functs, ALU ops, mux encodings and FSM states.
//          Optional macro ILLEGAL_TRAP_EN adds the HALT state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2a;

   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_SUB  = 2'd1;
   localparam logic [1:0] ALU_XOR  = 2'd2;
   localparam logic [1:0] ALU_SLT  = 2'd3;

   localparam logic [1:0] DW_ALU   = 2'd0;
   localparam logic [1:0] DW_LINK  = 2'd1;
   localparam logic [1:0] DW_MEM   = 2'd2;

   localparam logic [1:0] J_REG    = 2'd0;
   localparam logic [1:0] J_ADDR   = 2'd1;
   localparam logic [1:0] J_PC     = 2'd2;

   localparam logic [1:0] PC_INC   = 2'b00;
   localparam logic [1:0] PC_BEQ   = 2'b01;
   localparam logic [1:0] PC_BNE   = 2'b11;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
`ifdef ILLEGAL_TRAP_EN
   localparam logic [2:0] S_HALT   = 3'd5;
`endif

   typedef enum logic [3:0] {
      CLS_ILLEGAL,
      CLS_J,
      CLS_JR,
      CLS_JAL,
      CLS_RALU,
      CLS_IALU,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_BNE
   } instr_cls_e;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// ============================================================================
// Module : ctrl_decode
// Brief  : Combinational instruction classifier: class, aw, alu_op, imm_sel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_decode
   import multicycle_ctrl_pkg::*;
#(
   parameter int LINK_REG = 31
) (
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   output instr_cls_e  cls,
   output logic [4:0]  aw,
   output logic [1:0]  alu_op,
   output logic        imm_sel
);

   always_comb begin
      cls     = CLS_ILLEGAL;
      aw      = rt;
      alu_op  = ALU_ADD;
      imm_sel = 1'b0;
      case (op)
         OP_RTYPE: begin
            aw = rd;
            case (funct)
               FN_JR:   cls = CLS_JR;
               FN_ADD:  begin cls = CLS_RALU; alu_op = ALU_ADD; end
               FN_SUB:  begin cls = CLS_RALU; alu_op = ALU_SUB; end
               FN_SLT:  begin cls = CLS_RALU; alu_op = ALU_SLT; end
               default: cls = CLS_ILLEGAL;
            endcase
         end
         OP_J:    cls = CLS_J;
         OP_JAL:  begin cls = CLS_JAL; aw = 5'(LINK_REG); end
         OP_BEQ:  begin cls = CLS_BEQ; alu_op = ALU_SUB; end
         OP_BNE:  begin cls = CLS_BNE; alu_op = ALU_SUB; end
         OP_ADDI: begin cls = CLS_IALU; imm_sel = 1'b1; alu_op = ALU_ADD; end
         OP_XORI: begin cls = CLS_IALU; imm_sel = 1'b1; alu_op = ALU_XOR; end
         OP_LW:   begin cls = CLS_LW; imm_sel = 1'b1; alu_op = ALU_ADD; end
         OP_SW:   begin cls = CLS_SW; imm_sel = 1'b1; alu_op = ALU_ADD; end
         default: cls = CLS_ILLEGAL;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Multi-cycle MIPS-subset control FSM (fetch/decode/exec/mem/wb).
//          Optional macro ILLEGAL_TRAP_EN traps illegal instructions in HALT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int LINK_REG = 31,
   parameter int OPW      = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [31:0]    instr,
   input  logic           zero,
   input  logic           mem_ack,
   output logic [31:0]    ir_out,
   output logic [4:0]     aa,
   output logic [4:0]     ab,
   output logic [4:0]     aw,
   output logic [15:0]    imm,
   output logic [25:0]    jump_addr,
   output logic           imm_sel,
   output logic           mem_addr_sel,
   output logic           reg_wr_en,
   output logic           mem_wr_en,
   output logic           pc_wr_en,
   output logic           mem_req,
   output logic [1:0]     dw_sel,
   output logic [1:0]     pc_sel,
   output logic [1:0]     j_sel,
   output logic [OPW-1:0] alu_op,
   output logic           halted
);

   logic [2:0]  r_state;
   logic [2:0]  w_next;
   logic [31:0] r_ir;
   instr_cls_e  w_cls;
   logic [1:0]  w_alu_op;
   logic        w_imm_sel;
   logic        w_in_exec;
   logic        w_unused_zero;

   // Branch outcome is resolved in the datapath from zero and pc_sel.
   assign w_unused_zero = zero;

   ctrl_decode #(
      .LINK_REG (LINK_REG)
   ) u_decode (
      .op      (r_ir[31:26]),
      .funct   (r_ir[5:0]),
      .rt      (r_ir[20:16]),
      .rd      (r_ir[15:11]),
      .cls     (w_cls),
      .aw      (aw),
      .alu_op  (w_alu_op),
      .imm_sel (w_imm_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH) r_ir <= instr;
      end
   end

   assign ir_out       = r_ir;
   assign aa           = r_ir[25:21];
   assign ab           = r_ir[20:16];
   assign imm          = r_ir[15:0];
   assign jump_addr    = r_ir[25:0];
   assign mem_addr_sel = 1'b0;

   // ALU controls stay stable from EXEC through WB so operands and address hold.
   assign w_in_exec = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);
   assign alu_op    = w_in_exec ? OPW'(w_alu_op) : '0;
   assign imm_sel   = w_in_exec & w_imm_sel;

`ifdef ILLEGAL_TRAP_EN
   assign halted = (r_state == S_HALT);
`else
   assign halted = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      reg_wr_en = 1'b0;
      mem_wr_en = 1'b0;
      pc_wr_en  = 1'b0;
      mem_req   = 1'b0;
      dw_sel    = DW_ALU;
      pc_sel    = PC_INC;
      j_sel     = J_REG;
      case (r_state)
         S_FETCH: w_next = S_DECODE;
         S_DECODE: begin
            case (w_cls)
               CLS_J:   begin j_sel = J_ADDR; pc_wr_en = 1'b1; w_next = S_FETCH; end
               CLS_JR:  begin j_sel = J_REG;  pc_wr_en = 1'b1; w_next = S_FETCH; end
               CLS_JAL: w_next = S_WB;
               CLS_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                  w_next = S_HALT;
`else
                  j_sel    = J_PC;
                  pc_wr_en = 1'b1;
                  w_next   = S_FETCH;
`endif
               end
               default: w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (w_cls)
               CLS_LW, CLS_SW: w_next = S_MEM;
               CLS_BEQ, CLS_BNE: begin
                  pc_sel   = (w_cls == CLS_BNE) ? PC_BNE : PC_BEQ;
                  j_sel    = J_PC;
                  pc_wr_en = 1'b1;
                  w_next   = S_FETCH;
               end
               default: w_next = S_WB;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               if (w_cls == CLS_SW) begin
                  mem_wr_en = 1'b1;
                  j_sel     = J_PC;
                  pc_wr_en  = 1'b1;
                  w_next    = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end
         end
         S_WB: begin
            reg_wr_en = 1'b1;
            pc_wr_en  = 1'b1;
            j_sel     = (w_cls == CLS_JAL) ? J_ADDR : J_PC;
            dw_sel    = (w_cls == CLS_LW)  ? DW_MEM :
                        (w_cls == CLS_JAL) ? DW_LINK : DW_ALU;
            w_next    = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_HALT: w_next = S_HALT;
`endif
         default: w_next = S_FETCH;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Self-checking bench for multicycle_ctrl with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_ctrl;

   localparam int K_ILL = 0, K_J = 1, K_JR = 2, K_JAL = 3, K_R = 4;
   localparam int K_I = 5, K_LW = 6, K_SW = 7, K_BEQ = 8, K_BNE = 9;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ack;
   logic [31:0] ir_out;
   logic [4:0]  aa, ab, aw;
   logic [15:0] imm;
   logic [25:0] jump_addr;
   logic        imm_sel, mem_addr_sel, reg_wr_en, mem_wr_en, pc_wr_en, mem_req;
   logic [1:0]  dw_sel, pc_sel, j_sel;
   logic [2:0]  alu_op;
   logic        halted;

   int errors = 0;
   int checks = 0;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ack(mem_ack),
      .ir_out(ir_out), .aa(aa), .ab(ab), .aw(aw), .imm(imm), .jump_addr(jump_addr),
      .imm_sel(imm_sel), .mem_addr_sel(mem_addr_sel), .reg_wr_en(reg_wr_en),
      .mem_wr_en(mem_wr_en), .pc_wr_en(pc_wr_en), .mem_req(mem_req),
      .dw_sel(dw_sel), .pc_sel(pc_sel), .j_sel(j_sel), .alu_op(alu_op), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic int cls_of(input logic [31:0] i);
      case (i[31:26])
         6'h00: begin
            case (i[5:0])
               6'h08:               return K_JR;
               6'h20, 6'h22, 6'h2a: return K_R;
               default:             return K_ILL;
            endcase
         end
         6'h02:        return K_J;
         6'h03:        return K_JAL;
         6'h04:        return K_BEQ;
         6'h05:        return K_BNE;
         6'h08, 6'h0e: return K_I;
         6'h23:        return K_LW;
         6'h2b:        return K_SW;
         default:      return K_ILL;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr(input int c);
      logic [31:0] r;
      logic [5:0]  f;
      r = $urandom;
      case ($urandom_range(0, 2))
         0:       f = 6'h20;
         1:       f = 6'h22;
         default: f = 6'h2a;
      endcase
      case (c)
         K_J:     return {6'h02, r[25:0]};
         K_JR:    return {6'h00, r[25:21], 15'h0, 6'h08};
         K_JAL:   return {6'h03, r[25:0]};
         K_R:     return {6'h00, r[25:6], f};
         K_I:     return {(r[0] ? 6'h08 : 6'h0e), r[25:0]};
         K_LW:    return {6'h23, r[25:0]};
         K_SW:    return {6'h2b, r[25:0]};
         K_BEQ:   return {6'h04, r[25:0]};
         K_BNE:   return {6'h05, r[25:0]};
         default: return r[1] ? {6'h3f, r[25:0]} : {6'h00, r[25:6], 6'h01};
      endcase
   endfunction

   // Runs one instruction starting at a negedge in FETCH; ends at the next FETCH negedge.
   task automatic run_instr(input logic [31:0] i, input int delay, input logic z);
      int c, k, exp_cyc, exp_req, n_reg, n_mem, n_req, n_both, n_halt;
      logic done, last_reg, has_exec, exp_reg, exp_imm;
      int exp_mem;
      logic [4:0] got_aw, exp_aw;
      logic [1:0] got_dw, exp_dw, got_j, exp_j, got_pc, exp_pc;
      logic [2:0] exp_op;
      c        = cls_of(i);
      has_exec = c inside {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE};
      exp_reg  = c inside {K_R, K_I, K_LW, K_JAL};
      exp_mem  = (c == K_SW) ? 1 : 0;
      exp_req  = (c == K_LW || c == K_SW) ? delay + 1 : 0;
      exp_imm  = c inside {K_I, K_LW, K_SW};
      case (c)
         K_J, K_JR, K_ILL:   exp_cyc = 2;
         K_JAL, K_BEQ, K_BNE: exp_cyc = 3;
         K_R, K_I:           exp_cyc = 4;
         K_SW:               exp_cyc = 4 + delay;
         default:            exp_cyc = 5 + delay;
      endcase
      exp_aw = (c == K_JAL) ? 5'd31 : (c == K_R) ? i[15:11] : i[20:16];
      exp_dw = (c == K_LW) ? 2'd2 : (c == K_JAL) ? 2'd1 : 2'd0;
      exp_j  = (c == K_JR) ? 2'd0 : (c == K_J || c == K_JAL) ? 2'd1 : 2'd2;
      exp_pc = (c == K_BEQ) ? 2'b01 : (c == K_BNE) ? 2'b11 : 2'b00;
      exp_op = 3'd0;
      if (c == K_R && i[5:0] == 6'h22) exp_op = 3'd1;
      if (c == K_R && i[5:0] == 6'h2a) exp_op = 3'd3;
      if (c == K_I && i[31:26] == 6'h0e) exp_op = 3'd2;
      if (c == K_BEQ || c == K_BNE) exp_op = 3'd1;

      instr = i; zero = z;
      k = 0; done = 1'b0; last_reg = 1'b0;
      n_reg = 0; n_mem = 0; n_req = 0; n_both = 0; n_halt = 0;
      got_aw = '0; got_dw = '0; got_j = '0; got_pc = '0;
      while (!done && k < 40) begin
         k++;
         mem_ack = mem_req && (n_req == delay);
         if (mem_req) n_req++;
         #1;
         if (k == 2) begin
            checks++;
            if (ir_out !== i) begin errors++; $display("FAIL ir_out instr=%h got=%h exp=%h", i, ir_out, i); end
         end
         if (k == 3 && has_exec) begin
            checks++;
            if (alu_op !== exp_op) begin errors++; $display("FAIL alu_op instr=%h got=%0d exp=%0d", i, alu_op, exp_op); end
            checks++;
            if (imm_sel !== exp_imm) begin errors++; $display("FAIL imm_sel instr=%h got=%b exp=%b", i, imm_sel, exp_imm); end
         end
         if (reg_wr_en) begin n_reg++; got_aw = aw; got_dw = dw_sel; end
         if (mem_wr_en) n_mem++;
         if (reg_wr_en && mem_wr_en) n_both++;
         if (halted) n_halt++;
         if (pc_wr_en === 1'b1) begin
            done = 1'b1; got_j = j_sel; got_pc = pc_sel; last_reg = reg_wr_en;
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL timeout instr=%h no pc_wr_en within %0d cycles", i, k);
      end else if (k != exp_cyc) begin
         errors++; $display("FAIL cycles instr=%h got=%0d exp=%0d", i, k, exp_cyc);
      end
      checks++;
      if (n_reg != (exp_reg ? 1 : 0) || last_reg !== exp_reg) begin
         errors++; $display("FAIL reg_wr instr=%h got=%0d pulses last=%b exp=%b", i, n_reg, last_reg, exp_reg);
      end
      if (exp_reg) begin
         checks++;
         if (got_aw !== exp_aw) begin errors++; $display("FAIL aw instr=%h got=%0d exp=%0d", i, got_aw, exp_aw); end
         checks++;
         if (got_dw !== exp_dw) begin errors++; $display("FAIL dw_sel instr=%h got=%0d exp=%0d", i, got_dw, exp_dw); end
      end
      checks++;
      if (n_mem != exp_mem || n_both != 0) begin
         errors++; $display("FAIL mem_wr instr=%h got=%0d both=%0d exp=%0d", i, n_mem, n_both, exp_mem);
      end
      checks++;
      if (n_req != exp_req) begin errors++; $display("FAIL mem_req instr=%h got=%0d cycles exp=%0d", i, n_req, exp_req); end
      checks++;
      if (got_j !== exp_j || got_pc !== exp_pc) begin
         errors++; $display("FAIL pc_mux instr=%h got j=%0d pc=%0d exp j=%0d pc=%0d", i, got_j, got_pc, exp_j, exp_pc);
      end
      checks++;
      if (n_halt != 0) begin errors++; $display("FAIL halted instr=%h got=%0d cycles exp=0", i, n_halt); end
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr = 32'h00221820; mem_ack = 1'b1; zero = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({reg_wr_en, mem_wr_en, pc_wr_en, mem_req, imm_sel, mem_addr_sel, dw_sel,
           pc_sel, j_sel, alu_op, halted, aw} !== '0) begin
         errors++; $display("FAIL reset_outputs got nonzero controls exp all zero");
      end
      checks++;
      if (ir_out !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=0", ir_out); end
      mem_ack = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_sw();
      instr = 32'hAC450004; mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL sw_in_mem mem_req got=%b exp=1", mem_req); end
      rst_n = 1'b0;
      #1 mem_ack = 1'b1;
      #1;
      checks++;
      if ({reg_wr_en, mem_wr_en, pc_wr_en, mem_req, dw_sel, pc_sel, j_sel, alu_op, halted} !== '0) begin
         errors++; $display("FAIL reset_mid_sw outputs got nonzero exp all zero");
      end
      @(negedge clk);
      checks++;
      if (mem_wr_en !== 1'b0 || ir_out !== 32'h0) begin
         errors++; $display("FAIL reset_mid_sw hold mem_wr_en=%b ir=%h exp 0", mem_wr_en, ir_out);
      end
      rst_n = 1'b1;
      mem_ack = 1'b0;
      run_instr(32'h08000040, 0, 1'b0);
   endtask

   task automatic test_directed();
      run_instr(32'h00221820, 0, 1'b0);
      run_instr(32'h8C050010, 3, 1'b0);
      run_instr(32'h14220003, 0, 1'b0);
      run_instr(32'h10220003, 0, 1'b1);
      run_instr(32'h0C000100, 0, 1'b0);
      run_instr(32'hAC450004, 2, 1'b0);
      run_instr(32'h03E00008, 0, 1'b0);
      run_instr(32'h2021FFFF, 0, 1'b0);
      run_instr(32'h3862000F, 0, 1'b0);
      run_instr(32'h0043202A, 0, 1'b0);
   endtask

   task automatic test_back_to_back_random();
      int c;
      for (int n = 0; n < 60; n++) begin
`ifdef ILLEGAL_TRAP_EN
         c = int'($urandom_range(1, 9));
`else
         c = int'($urandom_range(0, 9));
`endif
         run_instr(rand_instr(c), int'($urandom_range(0, 4)), 1'($urandom));
      end
   endtask

   task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
      instr = 32'hFC000000;
      for (int k = 1; k <= 6; k++) begin
         #1;
         checks++;
         if (halted !== 1'(k >= 3)) begin errors++; $display("FAIL halted cycle=%0d got=%b exp=%b", k, halted, k >= 3); end
         checks++;
         if ({reg_wr_en, mem_wr_en, pc_wr_en, mem_req} !== 4'b0) begin
            errors++; $display("FAIL halt_enables cycle=%0d got=%b exp=0000", k, {reg_wr_en, mem_wr_en, pc_wr_en, mem_req});
         end
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (halted !== 1'b0) begin errors++; $display("FAIL halted_reset got=%b exp=0", halted); end
      @(negedge clk);
      rst_n = 1'b1;
`else
      run_instr(32'hFC000000, 0, 1'b0);
      run_instr(32'h00221801, 0, 1'b0);
`endif
   endtask

   initial begin
      test_reset();
      test_reset_mid_sw();
      test_directed();
      test_illegal();
      test_back_to_back_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
